// File: rtl/switch_bounce_generator.sv
// switch_bounce_generator: turns a clean level into an LFSR-timed mechanical contact-bounce waveform.
// Optional feature macro: BOUNCE_GEN_RETRIGGER_EN (an input change mid-bounce restarts the window).
module switch_bounce_generator #(
  parameter int unsigned BOUNCE_CYCLES = 250000,
  parameter int unsigned MIN_GAP       = 500,
  parameter int unsigned GAP_BITS      = 12,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic       out,
  output logic       busy,
  output logic [7:0] bounce_cnt
);

  localparam int unsigned WIN_W = $clog2(BOUNCE_CYCLES + 1);
  localparam int unsigned GAP_W = $clog2(MIN_GAP + (1 << GAP_BITS));
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t           state, state_next;
  logic [WIN_W-1:0] window;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_value;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic             target;
  logic             settle;
  logic             toggle;
  logic             retrig;

  // Galois LFSR, x^16+x^14+x^13+x^11+1
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign gap_value = GAP_W'(MIN_GAP) + GAP_W'(lfsr[GAP_BITS-1:0]);

  assign settle = (state == BOUNCE) && (window == WIN_LAST);
  assign toggle = (state == BOUNCE) && (gap == GAP_W'(1)) && (window < WIN_LAST);

`ifdef BOUNCE_GEN_RETRIGGER_EN
  assign retrig = (state == BOUNCE) && (in != target);
`else
  assign retrig = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in != out) state_next = BOUNCE;
      BOUNCE:  if (!retrig && settle) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == BOUNCE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= 1'b0;
      target     <= 1'b0;
      window     <= '0;
      gap        <= '0;
      bounce_cnt <= 8'd0;
      lfsr       <= SEED;
    end else begin
      lfsr <= lfsr_next;
      case (state)
        IDLE: begin
          if (in != out) begin
            out        <= in;
            target     <= in;
            window     <= '0;
            gap        <= gap_value;
            bounce_cnt <= 8'd0;
          end
        end
        BOUNCE: begin
          window <= window + 1'b1;
          gap    <= gap - 1'b1;
          if (toggle) begin
            gap        <= gap_value;
            bounce_cnt <= bounce_cnt + {7'd0, (bounce_cnt != 8'hFF)};
          end
          // A retrigger suppresses the settle so the restarted window keeps bouncing
          if (retrig) begin
            target <= in;
            window <= '0;
          end
          if (settle && !retrig) out <= target;
          else if (toggle)       out <= ~out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_bounce_generator.sv
// Directed self-checking bench for switch_bounce_generator: reset, idle, single event,
// reset replay, retrigger (both macro builds) and bounce_cnt saturation.
module tb_switch_bounce_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in;
  logic       out;
  logic       busy;
  logic [7:0] bounce_cnt;

  logic       reset2;
  logic       in2;
  logic       out2;
  logic       busy2;
  logic [7:0] bounce_cnt2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  switch_bounce_generator #(
    .BOUNCE_CYCLES(100), .MIN_GAP(4), .GAP_BITS(3), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .in(in), .out(out), .busy(busy), .bounce_cnt(bounce_cnt)
  );

  switch_bounce_generator #(
    .BOUNCE_CYCLES(5000), .MIN_GAP(1), .GAP_BITS(1), .LFSR_SEED(16'hACE1)
  ) dut_sat (
    .clk(clk), .reset(reset2), .in(in2), .out(out2), .busy(busy2), .bounce_cnt(bounce_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset with in=0, then a fixed idle gap so the LFSR phase at the event edge is repeatable
  task automatic do_reset();
    in    = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    int   edges, last_edge, sp, min_sp, max_sp, busy_cycles, changes, busy_seen;
    int   sat_seen, sat_broken;
    logic prev;
    logic trace_a [0:40];
    logic trace_b [0:40];
    logic [7:0] held_cnt;

    reset  = 1'b1;
    in     = 1'b1;
    reset2 = 1'b1;
    in2    = 1'b0;

    // Reset dominates even with in=1
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_out", out, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", bounce_cnt, 0);
    end
    in = 1'b0;
    tick();
    reset = 1'b0;

    // Idle stability
    changes = 0; busy_seen = 0; prev = out;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (out != prev) changes++;
      if (busy) busy_seen++;
      prev = out;
    end
    check("idle_changes", changes, 0);
    check("idle_busy", busy_seen, 0);

    // Run A: event interrupted by reset at window=40
    do_reset();
    n = cyc;
    in = 1'b1;
    tick();
    check("runa_out_first", out, 1);
    check("runa_busy_first", busy, 1);
    trace_a[0] = out;
    for (int i = 1; i <= 40; i++) begin
      tick();
      trace_a[i] = out;
    end
    check("runa_window40_cycle", cyc - n, 41);
    reset = 1'b1;
    tick();
    check("midrst_out", out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cnt", bounce_cnt, 0);
    reset = 1'b0;

    // Run B: identical stimulus, full single event
    do_reset();
    n = cyc;
    in = 1'b1;
    tick();
    check("evt_out_first", out, 1);
    check("evt_busy_first", busy, 1);
    trace_b[0] = out;
    edges = 1; last_edge = cyc; min_sp = 1000; max_sp = 0; busy_cycles = 1; prev = out;
    for (int i = 1; i < 100; i++) begin
      tick();
      if (i <= 40) trace_b[i] = out;
      if (busy) busy_cycles++;
      if (out != prev) begin
        sp = cyc - last_edge;
        if (sp < min_sp) min_sp = sp;
        if (sp > max_sp) max_sp = sp;
        last_edge = cyc;
        edges++;
      end
      prev = out;
    end
    tick();
    check("evt_settle_cycle", cyc - n, 101);
    check("evt_busy_fall", busy, 0);
    check("evt_out_settled", out, 1);
    check("evt_busy_cycles", busy_cycles, 100);
    check("evt_cnt_vs_edges", bounce_cnt, edges - 1);
    check("evt_cnt_range", (bounce_cnt >= 8) && (bounce_cnt <= 24), 1);
    check("evt_min_spacing_ge4", min_sp >= 4, 1);
    check("evt_max_spacing_le11", max_sp <= 11, 1);
    for (int i = 0; i <= 40; i++) check($sformatf("replay_%0d", i), trace_b[i], trace_a[i]);

    // bounce_cnt holds while input is stable
    held_cnt = bounce_cnt;
    changes = 0; prev = out;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out != prev) changes++;
      prev = out;
    end
    check("hold_cnt", bounce_cnt, held_cnt);
    check("hold_busy", busy, 0);
    check("hold_out_stable", changes, 0);

    // Retrigger: 0->1 at N, 1->0 at N+50
    do_reset();
    n = cyc;
    in = 1'b1;
    busy_cycles = 0;
    repeat (50) begin
      tick();
      if (busy) busy_cycles++;
    end
    in = 1'b0;
`ifdef BOUNCE_GEN_RETRIGGER_EN
    while (cyc < n + 150) begin
      tick();
      if (busy) busy_cycles++;
    end
    check("retrig_busy_cont", busy_cycles, 150);
    tick();
    check("retrig_settle_busy", busy, 0);
    check("retrig_settle_out", out, 0);
`else
    while (cyc < n + 100) begin
      tick();
      if (busy) busy_cycles++;
    end
    check("noretrig_busy1", busy_cycles, 100);
    tick();
    check("noretrig_fall_busy", busy, 0);
    check("noretrig_fall_out", out, 1);
    tick();
    check("noretrig_new_busy", busy, 1);
    check("noretrig_new_out", out, 0);
    busy_cycles = 1;
    while (cyc < n + 201) begin
      tick();
      if (busy) busy_cycles++;
    end
    check("noretrig_busy2", busy_cycles, 100);
    tick();
    check("noretrig_settle_busy", busy, 0);
    check("noretrig_settle_out", out, 0);
`endif

    // Saturation on the fast-toggling instance
    reset2 = 1'b1;
    repeat (2) tick();
    reset2 = 1'b0;
    repeat (3) tick();
    n = cyc;
    in2 = 1'b1;
    sat_seen = 0; sat_broken = 0; busy_cycles = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (busy2) busy_cycles++;
      if (sat_seen != 0 && bounce_cnt2 != 8'd255) sat_broken++;
      if (bounce_cnt2 == 8'd255) sat_seen = 1;
    end
    check("sat_busy_cycles", busy_cycles, 5000);
    tick();
    check("sat_busy_fall", busy2, 0);
    check("sat_out_settled", out2, 1);
    check("sat_cnt", bounce_cnt2, 255);
    check("sat_reached", sat_seen, 1);
    check("sat_held", sat_broken, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_bounce_generator.md
Name: switch_bounce_generator

Overview:
- Turns a clean level input into a contact-bounce waveform like a mechanical switch produces. The output bounces pseudorandomly for a fixed window, then settles to the new level.
- Sits in front of the synchroniser/debouncer chain as an on-chip stimulus source. Lets the debounced and raw transition counts on the HEX displays be compared without a physical switch.
- Timing is deterministic from reset via an internal 16-bit LFSR.

Parameters:
- BOUNCE_CYCLES, 250000, length of the bounce window in clk cycles (5 ms at 50 MHz); must be >= 2.
- MIN_GAP, 500, minimum spacing in cycles between output toggles; must be >= 1.
- GAP_BITS, 12, number of LFSR bits added to MIN_GAP for random extra spacing (0..2^GAP_BITS-1); 1..16.
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  1  clean requested switch level; already synchronous to clk.
- out  output  1  bouncy switch level, registered.
- busy  output  1  high while in the BOUNCE state.
- bounce_cnt  output  8  number of glitch toggles in the current or last event; saturates at 255.

Behaviour:
- Reset (synchronous, wins over everything):
  - out=0, busy=0, bounce_cnt=0.
  - State=IDLE, window counter=0, gap counter=0, target=0, lfsr=LFSR_SEED.
- LFSR:
  - Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Advances every cycle except during reset, in every state.
  - gap value G = MIN_GAP + lfsr[GAP_BITS-1:0], zero-extended, taken from the current lfsr value.
- Counter widths:
  - Window counter: $clog2(BOUNCE_CYCLES+1) bits.
  - Gap counter: wide enough to hold MIN_GAP + 2^GAP_BITS - 1.
- IDLE:
  - busy=0; out holds its value.
  - If in != out: go to BOUNCE, out<=in, target<=in, window<=0, gap<=G, bounce_cnt<=0.
  - The first edge on out appears 1 cycle after in changes.
- BOUNCE:
  - busy=1; window increments each cycle; gap decrements each cycle.
  - Toggle: when gap==1 and window < BOUNCE_CYCLES-1, out<=~out, reload gap<=G, bounce_cnt<=bounce_cnt+1 (saturating at 255). Consecutive out edges are therefore exactly G cycles apart.
  - Settle: when window==BOUNCE_CYCLES-1, out<=target and go to IDLE. This takes priority over a toggle on the same cycle.
  - busy is high for exactly BOUNCE_CYCLES cycles per non-retriggered event.
  - When busy falls, out==target.
- Input change during BOUNCE: handled according to the optional feature below.
- Stable input:
  - If in==out in IDLE, no activity.
  - bounce_cnt holds the last event's count until the next event starts.
- Reset mid-BOUNCE: out=0 and busy=0 on the next edge; all bounce activity stops.

Optional Feature:
- Macro: BOUNCE_GEN_RETRIGGER_EN.
- Defined: an in change (in != target) during BOUNCE sets target<=in and window<=0.
  - The window restarts and bouncing continues; busy stays high with no gap.
  - bounce_cnt is not cleared.
- Undefined: in is ignored during BOUNCE and target stays frozen.
  - After settling to the old target, IDLE sees in != out on the next cycle and starts a new event.

Test Plan:
- Reset: hold in=1 and assert reset for 3 cycles -> out=0, busy=0, bounce_cnt=0 throughout reset.
- Single event (BOUNCE_CYCLES=100, MIN_GAP=4, GAP_BITS=3): in 0->1 at cycle N -> out=1 and busy=1 at N+1.
  - Out-edge spacing is 4..11 cycles.
  - busy falls with out=1 at N+101.
  - bounce_cnt is 8..24 and equals the number of out edges in the window minus the first edge.
- Idle stability: in held equal to out for 1000 cycles -> busy stays 0 and out never changes.
- Retrigger (same parameters): in 0->1 at N, then 1->0 at N+50.
  - Macro defined -> busy high continuously; out settles to 0 at N+151.
  - Macro undefined -> out settles to 1 at N+101, busy low 1 cycle, then a new event settles out=0 at N+202.
- Saturation (BOUNCE_CYCLES=5000, MIN_GAP=1, GAP_BITS=1): one event -> bounce_cnt reaches 255 and holds; out still settles correctly.
- Reset mid-BOUNCE at window=40, then repeat the same in stimulus -> out=0/busy=0 one cycle after reset; the repeated event reproduces the first run's out trace cycle for cycle.
